lfsr_timer_sched: RTL

- Round-robin scheduler that shares one 4-bit LFSR terminal counter (load / count_en / count_to / done interface) among N_REQ requesters.
- Each requester asks for a count_to value. The scheduler loads the counter, enables counting and waits for done, guarded by a watchdog.
- It then returns a one-cycle ack, or err on timeout or invalid value, to the granted requester.
- Sits between the requesting control blocks and the LFSR counter instance; it is the only driver of the counter's load/count_en/count_to.

---
 rtl/lfsr_timer_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/lfsr_timer_sched.sv
// Round-robin scheduler that time-shares one LFSR terminal counter among N_REQ requesters.
// Each service loads the counter, waits for done under a watchdog, then pulses ack or err.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no service active; arbitrate from rr_ptr when any req is set
// LOAD    | one-cycle load strobe with the captured count_to value
// COUNT   | counter enabled; wait for done or watchdog expiry
// RELEASE | one-cycle ack/err pulse to the granted requester
module lfsr_timer_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int WDOG  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CNT_W-1:0]   req_cnt,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         err,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     lfsr_load,
  output logic                     lfsr_count_en,
  output logic [CNT_W-1:0]         lfsr_count_to,
  input  logic                     lfsr_done
);

  localparam int GW = $clog2(N_REQ);
  localparam int SW = GW + 1;
  localparam int WW = $clog2(WDOG + 1);
  localparam logic [SW-1:0] N_SW   = SW'(N_REQ);
  localparam logic [WW-1:0] WD_END = WW'(WDOG - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, RELEASE} state_t;

  state_t               state;
  logic [GW-1:0]        rr_ptr;
  logic [WW-1:0]        wdog;
  logic [2*N_REQ-1:0]   req_rot;
  logic                 any_req;
  logic [GW-1:0]        pick_off;
  logic [SW-1:0]        pick_sum;
  logic [GW-1:0]        pick;
  logic [CNT_W-1:0]     cnt_sel;

  // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit is the winner.
  assign req_rot = {req, req} >> rr_ptr;

  always_comb begin
    any_req  = 1'b0;
    pick_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        any_req  = 1'b1;
        pick_off = GW'(i);
      end
    end
  end

  assign pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
  assign pick     = (pick_sum >= N_SW) ? GW'(pick_sum - N_SW) : pick_sum[GW-1:0];

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == GW'(i)) cnt_sel = req_cnt[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ack           <= '0;
      err           <= '0;
      busy          <= 1'b0;
      grant_id      <= '0;
      lfsr_load     <= 1'b0;
      lfsr_count_en <= 1'b0;
      lfsr_count_to <= '0;
      rr_ptr        <= '0;
      wdog          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= pick;
            busy     <= 1'b1;
            // Zero is the LFSR lockup value, so it is rejected without touching the counter.
            if (cnt_sel == '0) begin
              err   <= N_REQ'(1) << pick;
              state <= RELEASE;
            end else begin
              lfsr_count_to <= cnt_sel;
              lfsr_load     <= 1'b1;
              state         <= LOAD;
            end
          end
        end
        LOAD: begin
          lfsr_load     <= 1'b0;
          lfsr_count_en <= 1'b1;
          wdog          <= '0;
          state         <= COUNT;
        end
        COUNT: begin
          if (lfsr_done) begin
            ack           <= N_REQ'(1) << grant_id;
            lfsr_count_en <= 1'b0;
            state         <= RELEASE;
          end else if (wdog == WD_END) begin
            err           <= N_REQ'(1) << grant_id;
            lfsr_count_en <= 1'b0;
            state         <= RELEASE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RELEASE: begin
          ack    <= '0;
          err    <= '0;
          busy   <= 1'b0;
          rr_ptr <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
